// File: rtl/dmem_arbiter.sv
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Round-robin req/gnt/done arbiter sharing one data memory
//                between a core port (0) and a host/debug port (1).
//                Optional perf counters: define DMEM_ARB_PERF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 16,
    parameter int MEM_LAT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [15:0]       gcnt0,
    output logic [15:0]       gcnt1,
    output logic [15:0]       ccnt
`endif
);

    localparam int         c_CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_ACCESS = 2'd1;
    localparam logic [1:0] c_S_DONE   = 2'd2;
    localparam logic       c_LAT1     = (MEM_LAT == 1);

    logic [1:0]         r_state;
    logic               r_last;
    logic               r_port;
    logic               r_we;
    logic               r_oor;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_any_req;
    logic               w_both_req;
    logic               w_win1;
    logic               w_we;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_wdata;
    logic               w_in_range;
    logic [DATA_W-1:0]  w_rd_val;

    assign w_any_req  = req0 | req1;
    assign w_both_req = req0 & req1;
    // On contention the port that did not win last time gets the memory.
    assign w_win1     = req1 & (~req0 | ~r_last);
    assign w_we       = w_win1 ? we1    : we0;
    assign w_addr     = w_win1 ? addr1  : addr0;
    assign w_wdata    = w_win1 ? wdata1 : wdata0;
    assign w_in_range = (w_addr >> 2) < ADDR_W'(MEM_DEPTH);
    assign w_rd_val   = r_oor ? '0 : mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_S_IDLE;
            r_last    <= 1'b1;
            r_port    <= 1'b0;
            r_we      <= 1'b0;
            r_oor     <= 1'b0;
            r_cnt     <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_any_req) begin
                        r_state <= c_S_ACCESS;
                        r_port  <= w_win1;
                        r_we    <= w_we;
                        r_oor   <= ~w_in_range;
                        r_cnt   <= c_CNT_W'(MEM_LAT - 1);
                        gnt0    <= ~w_win1;
                        gnt1    <= w_win1;
                        if (w_both_req) begin
                            r_last <= w_win1;
                        end
                        if (w_in_range) begin
                            mem_en    <= 1'b1;
                            mem_addr  <= w_addr;
                            mem_wdata <= w_wdata;
                            mem_we    <= w_we & c_LAT1;
                        end
                    end
                end

                c_S_ACCESS: begin
                    if (r_cnt == '0) begin
                        r_state   <= c_S_DONE;
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        if (r_port) begin
                            done1 <= 1'b1;
                            err1  <= r_oor;
                            if (!r_we) begin
                                rdata1 <= w_rd_val;
                            end
                        end else begin
                            done0 <= 1'b0 | 1'b1;
                            err0  <= r_oor;
                            if (!r_we) begin
                                rdata0 <= w_rd_val;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                        // Strobe the write only in the final access cycle.
                        if ((r_cnt == c_CNT_W'(1)) && !r_oor) begin
                            mem_we <= r_we;
                        end
                    end
                end

                c_S_DONE: begin
                    r_state <= c_S_IDLE;
                    gnt0    <= 1'b0;
                    gnt1    <= 1'b0;
                    done0   <= 1'b0;
                    done1   <= 1'b0;
                    err0    <= 1'b0;
                    err1    <= 1'b0;
                end

                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic w_grant;
    assign w_grant = (r_state == c_S_IDLE) & w_any_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gcnt0 <= '0;
            gcnt1 <= '0;
            ccnt  <= '0;
        end else begin
            if (w_grant && !w_win1 && (gcnt0 != 16'hFFFF)) begin
                gcnt0 <= gcnt0 + 16'd1;
            end
            if (w_grant && w_win1 && (gcnt1 != 16'hFFFF)) begin
                gcnt1 <= gcnt1 + 16'd1;
            end
            if ((r_state == c_S_IDLE) && w_both_req && (ccnt != 16'hFFFF)) begin
                ccnt <= ccnt + 16'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire
